// File: rtl/adc_ctrl_rx_pkg.sv
// Shared definitions for the front-panel SPI control-word receiver.
//   WordBitsDef  : default frame length in bits
//   DefaultFreq  : power-up oscillator frequency word
//   HistDepth    : depth of the optional averaging history
//   spi_state_e  : receiver FSM encoding (IDLE=00, SHIFT=01, DONE=10)
package adc_ctrl_rx_pkg;

  localparam int unsigned WordBitsDef = 16;
  localparam logic [15:0] DefaultFreq = 16'd1000;
  localparam int unsigned HistDepth   = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } spi_state_e;

endpackage

// File: rtl/adc_ctrl_rx_sync.sv
// Multi-flop synchroniser for one asynchronous input, plus a one-cycle delayed copy of the
// synchronised level so the parent can form rising/falling edge strobes.
// Ports:
//   clock      : fpga clock
//   reset      : asynchronous, active-high; all flops clear to 0
//   i_async    : asynchronous input
//   o_level    : synchronised level (SYNC_STAGES flops deep)
//   o_level_d  : o_level delayed by one clock (edge-detect reference)
module adc_ctrl_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_level_d
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Clearing to 0 means an input already low at reset release never looks like a fall.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level   = r_sync[SYNC_STAGES-1];
  assign o_level_d = r_prev;

endmodule

// File: rtl/adc_ctrl_rx.sv
// SPI-slave (mode 0) receiver for the 16-bit oscillator control word from the front-panel MCU.
// Resynchronises NSS/SCK/MOSI into the fpga clock domain, assembles MSB-first words and presents
// a held word with a one-cycle valid strobe.
// Ports:
//   clock        : fpga clock
//   reset        : asynchronous, active-high
//   spi_nss      : MCU chip select, active-low, asynchronous
//   spi_clock_in : MCU SCK, idle low, asynchronous
//   spi_data_in  : MCU MOSI, asynchronous
//   data_out     : last accepted word (or running average), held between frames
//   data_valid   : one-cycle pulse when data_out updates
//   frame_err    : one-cycle pulse on a short frame (1..WORD_BITS-1 bits)
//   overrun      : sticky, more than WORD_BITS SCK rises in one frame; cleared by reset only
// Build option: define ADC_CTRL_RX_AVG_EN to output the truncated mean of the last four accepted
// words (history primed to DEFAULT_WORD) with one extra clock of latency.
module adc_ctrl_rx
  import adc_ctrl_rx_pkg::*;
#(
  parameter int unsigned          WORD_BITS    = WordBitsDef,
  parameter int unsigned          SYNC_STAGES  = 2,
  parameter logic [WORD_BITS-1:0] DEFAULT_WORD = WORD_BITS'(DefaultFreq)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_nss,
  input  logic                 spi_clock_in,
  input  logic                 spi_data_in,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(WORD_BITS + 1);

  // ---------------------------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------------------------
  logic w_nss_level, w_nss_level_d;
  logic w_sck_level, w_sck_level_d;
  logic [SYNC_STAGES-1:0] r_mosi_sync;

  adc_ctrl_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_nss (
    .clock     (clock),
    .reset     (reset),
    .i_async   (spi_nss),
    .o_level   (w_nss_level),
    .o_level_d (w_nss_level_d)
  );

  adc_ctrl_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_sck (
    .clock     (clock),
    .reset     (reset),
    .i_async   (spi_clock_in),
    .o_level   (w_sck_level),
    .o_level_d (w_sck_level_d)
  );

  // MOSI needs no edge detect; same depth keeps it aligned with the SCK rise strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_data_in};
    end
  end

  logic w_mosi, w_sck_rise, w_nss_high, w_nss_fall;
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_level & ~w_sck_level_d;
  assign w_nss_high = w_nss_level;
  // Starting on a fall (not a low level) means a frame cut by reset is not resumed.
  assign w_nss_fall = ~w_nss_level & w_nss_level_d;

  // ---------------------------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------------------------
  spi_state_e           r_state, w_state_nxt;
  logic [CntW-1:0]      r_cnt, w_cnt_nxt;
  logic [WORD_BITS-1:0] r_shift, w_shift_nxt;
  logic                 w_accept, w_ferr, w_ovr_set;
  logic                 r_accept, r_frame_err, r_overrun;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_accept    <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_accept    <= w_accept;
      r_frame_err <= w_ferr;
      r_overrun   <= r_overrun | w_ovr_set;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_accept    = 1'b0;
    w_ferr      = 1'b0;
    w_ovr_set   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_nss_fall) begin
          w_state_nxt = StShift;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end
      end
      StShift: begin
        // The SCK edge is counted before NSS is looked at, so a final edge coinciding with
        // NSS rising still completes the word.
        if (w_sck_rise) begin
          w_shift_nxt = {r_shift[WORD_BITS-2:0], w_mosi};
          w_cnt_nxt   = r_cnt + 1'b1;
        end
        if (w_sck_rise && (r_cnt == CntW'(WORD_BITS - 1))) begin
          w_accept    = 1'b1;
          w_state_nxt = StDone;
        end else if (w_nss_high) begin
          w_ferr      = (w_cnt_nxt != '0);
          w_state_nxt = StIdle;
        end
      end
      StDone: begin
        if (w_sck_rise) begin
          w_ovr_set = 1'b1;
        end
        if (w_nss_high) begin
          w_state_nxt = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------------------------
  logic [WORD_BITS-1:0] r_data;
  logic                 r_valid;

`ifdef ADC_CTRL_RX_AVG_EN
  logic [WORD_BITS-1:0] r_hist [HistDepth];
  logic                 r_hist_upd;
  logic [WORD_BITS+1:0] w_sum;

  assign w_sum = (WORD_BITS+2)'(r_hist[0]) + (WORD_BITS+2)'(r_hist[1]) +
                 (WORD_BITS+2)'(r_hist[2]) + (WORD_BITS+2)'(r_hist[3]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < HistDepth; i++) begin
        r_hist[i] <= DEFAULT_WORD;
      end
      r_hist_upd <= 1'b0;
      r_data     <= DEFAULT_WORD;
      r_valid    <= 1'b0;
    end else begin
      r_hist_upd <= r_accept;
      r_valid    <= r_hist_upd;
      if (r_accept) begin
        for (int i = HistDepth - 1; i > 0; i--) begin
          r_hist[i] <= r_hist[i-1];
        end
        r_hist[0] <= r_shift;
      end
      if (r_hist_upd) begin
        r_data <= WORD_BITS'(w_sum >> 2);
      end
    end
  end
`else
  // r_shift is frozen in DONE, so it still holds the completed word one clock later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= DEFAULT_WORD;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_accept;
      if (r_accept) begin
        r_data <= r_shift;
      end
    end
  end
`endif

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_adc_ctrl_rx.sv
`timescale 1ns/1ps
module tb_adc_ctrl_rx;

  localparam int unsigned WB  = 16;
  localparam int unsigned SS  = 2;
  localparam logic [15:0] DEF = 16'd1000;
`ifdef ADC_CTRL_RX_AVG_EN
  localparam int LAT = SS + 3;
`else
  localparam int LAT = SS + 2;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        spi_nss = 1'b1;
  logic        spi_clock_in = 1'b0;
  logic        spi_data_in = 1'b0;
  logic [15:0] data_out;
  logic        data_valid, frame_err, overrun;

  adc_ctrl_rx #(
    .WORD_BITS    (WB),
    .SYNC_STAGES  (SS),
    .DEFAULT_WORD (DEF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .spi_nss      (spi_nss),
    .spi_clock_in (spi_clock_in),
    .spi_data_in  (spi_data_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #7 clock = ~clock;

  // ---------------- bookkeeping ----------------
  int unsigned vecs = 0;
  int unsigned errs = 0;
  int          cyc  = 0;

  typedef struct {
    int          due;
    logic [15:0] word;
  } ev_t;

  ev_t         acc_q[$];          // accepted words and the cycle their data_valid is due
  int          hist[4] = '{1000, 1000, 1000, 1000};
  logic [15:0] exp_out = DEF;
  bit          model_ovr = 1'b0;
  int          ferr_pend = 0;
  int          ferr_seen = 0;
  logic [15:0] dv_log[$];
  int          last_dv_cyc = 0;
  int          last_rise_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Model of what an accepted word does to data_out.
  task automatic model_accept(input logic [15:0] w);
`ifdef ADC_CTRL_RX_AVG_EN
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = int'(w);
    exp_out = 16'((hist[0] + hist[1] + hist[2] + hist[3]) / 4);
`else
    exp_out = w;
`endif
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      begin
        bit exp_dv;
        exp_dv = 1'b0;
        if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
          exp_dv = 1'b1;
          model_accept(acc_q[0].word);
          void'(acc_q.pop_front());
        end
        chk("data_valid", {31'd0, data_valid}, {31'd0, exp_dv});
        chk("data_out", {16'd0, data_out}, {16'd0, exp_out});
      end
      if (data_valid === 1'b1) begin
        dv_log.push_back(data_out);
        last_dv_cyc = cyc;
      end
      if (frame_err === 1'b1) begin
        ferr_seen++;
        vecs++;
        if (ferr_pend == 0) begin
          errs++;
          $display("FAIL frame_err_unexpected: got pulse, expected none, cycle %0d", cyc);
        end else begin
          ferr_pend--;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clock);
    reset = 1'b1;
    acc_q.delete();
    exp_out   = DEF;
    model_ovr = 1'b0;
    ferr_pend = 0;
    for (int i = 0; i < 4; i++) hist[i] = 1000;
    wait_clks(hold);
    reset = 1'b0;
  endtask

  // Raw SCK pulse with no model effect (used only where the DUT must ignore it).
  task automatic raw_pulse(input bit b, input int h);
    spi_data_in = b;
    wait_clks(h);
    spi_clock_in = 1'b1;
    wait_clks(h);
    spi_clock_in = 1'b0;
  endtask

  // One frame: nbits MSB-first from bits; h = SCK half period in clocks.
  task automatic frame(input logic [31:0] bits, input int nbits, input int h,
                       input bit nss_with_last);
    logic [15:0] acc;
    acc = '0;
    @(negedge clock);
    spi_nss = 1'b0;
    wait_clks(h);
    for (int i = 0; i < nbits; i++) begin
      spi_data_in = bits[nbits-1-i];
      wait_clks(h);
      spi_clock_in = 1'b1;
      if (i < WB) acc = {acc[14:0], bits[nbits-1-i]};
      if (i + 1 == WB) begin
        acc_q.push_back('{due: cyc + LAT, word: acc});
        last_rise_cyc = cyc;
      end
      if (i + 1 > WB) model_ovr = 1'b1;
      if (nss_with_last && i == nbits - 1) begin
        spi_nss = 1'b1;
        if (nbits < WB) ferr_pend++;
      end
      wait_clks(h);
      spi_clock_in = 1'b0;
    end
    wait_clks(h);
    if (spi_nss == 1'b0) begin
      spi_nss = 1'b1;
      if (nbits >= 1 && nbits < WB) ferr_pend++;
    end
    wait_clks(SS + LAT + 6);
    chk("frame_err_missing", ferr_pend, 0);
    chk("overrun", {31'd0, overrun}, {31'd0, model_ovr});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int f0;
    reset = 1'b1;
    do_reset(4);

    // 1: idle after reset
    wait_clks(30);
    chk("reset_data_out", {16'd0, data_out}, 32'd1000);
    chk("reset_no_valid", dv_log.size(), 0);
    chk("reset_overrun", {31'd0, overrun}, 0);

    // 2: 0x0BB8 at ~4 MHz SCK (9-clock half period)
    frame(32'h0BB8, 16, 9, 1'b0);
    chk("t2_valid_count", dv_log.size(), 1);
`ifdef ADC_CTRL_RX_AVG_EN
    chk("t2_data_out", {16'd0, dv_log[0]}, 32'd1500);
`else
    chk("t2_data_out", {16'd0, dv_log[0]}, 32'd3000);
`endif
    chk("t2_latency", last_dv_cyc - last_rise_cyc, LAT);

    // 3: short frame of 9 ones, then 440
    dv_log.delete();
    f0 = ferr_seen;
    frame(32'h1FF, 9, 5, 1'b0);
    chk("t3_ferr_pulses", ferr_seen - f0, 1);
    chk("t3_no_valid", dv_log.size(), 0);
`ifdef ADC_CTRL_RX_AVG_EN
    chk("t3_held", {16'd0, data_out}, 32'd1500);
    frame(32'd440, 16, 4, 1'b0);
    chk("t3_next_word", {16'd0, data_out}, 32'd1360);
`else
    chk("t3_held", {16'd0, data_out}, 32'd3000);
    frame(32'd440, 16, 4, 1'b0);
    chk("t3_next_word", {16'd0, data_out}, 32'd440);
`endif

    // 4: 18 rises carrying 0x1234 then two extra bits
    frame({14'd0, 16'h1234, 2'b11}, 18, 3, 1'b0);
`ifdef ADC_CTRL_RX_AVG_EN
    chk("t4_data_out", {16'd0, data_out}, 32'd2275);
`else
    chk("t4_data_out", {16'd0, data_out}, 32'h1234);
`endif
    chk("t4_overrun_set", {31'd0, overrun}, 1);
    frame(32'h00AA, 16, 3, 1'b0);
    chk("t4_overrun_sticky", {31'd0, overrun}, 1);

    // 5: reset after 8 bits, then 2000
    f0 = ferr_seen;
    @(negedge clock);
    spi_nss = 1'b0;
    wait_clks(4);
    for (int i = 0; i < 8; i++) raw_pulse(1'b1, 4);
    do_reset(3);
    wait_clks(2);
    chk("t5_reset_data_out", {16'd0, data_out}, 32'd1000);
    chk("t5_reset_overrun", {31'd0, overrun}, 0);
    for (int i = 0; i < 10; i++) raw_pulse(1'b1, 4);  // NSS never seen high: ignored
    spi_nss = 1'b1;
    wait_clks(12);
    chk("t5_held_after_stray", {16'd0, data_out}, 32'd1000);
    frame(32'd2000, 16, 4, 1'b0);
    chk("t5_no_ferr", ferr_seen - f0, 0);
`ifdef ADC_CTRL_RX_AVG_EN
    chk("t5_data_out", {16'd0, data_out}, 32'd1250);
`else
    chk("t5_data_out", {16'd0, data_out}, 32'd2000);
`endif

    // 6: averaging ramp
`ifdef ADC_CTRL_RX_AVG_EN
    do_reset(3);
    wait_clks(4);
    dv_log.delete();
    for (int i = 0; i < 4; i++) begin
      frame(32'd2000, 16, 3, 1'b0);
      chk("t6_latency", last_dv_cyc - last_rise_cyc, SS + 3);
    end
    chk("t6_count", dv_log.size(), 4);
    chk("t6_avg0", {16'd0, dv_log[0]}, 32'd1250);
    chk("t6_avg1", {16'd0, dv_log[1]}, 32'd1500);
    chk("t6_avg2", {16'd0, dv_log[2]}, 32'd1750);
    chk("t6_avg3", {16'd0, dv_log[3]}, 32'd2000);
`endif

    // Boundary: final edge coincides with NSS rise
    frame(32'hBEEF, 16, 4, 1'b1);
    frame(32'h0155, 9, 4, 1'b1);

    // Random frames
    do_reset(3);
    wait_clks(4);
    for (int n = 0; n < 40; n++) begin
      int nb;
      nb = ($urandom_range(0, 9) < 6) ? 16 : int'($urandom_range(0, 20));
      frame($urandom, nb, int'($urandom_range(3, 9)), ($urandom_range(0, 3) == 0));
    end
    wait_clks(10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #(14 * 90000);
    $display("FAIL timeout: simulation did not complete, expected finish before cycle 90000");
    $fatal(1);
  end

endmodule
